// File: rtl/instr_loader_pkg.sv
// Shared types and default sizes for the instruction-memory loader.
package instr_pkg;

  localparam int unsigned D = 12;  // instruction address width
  localparam int unsigned W = 9;   // machine-code word width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [W-1:0] mach_word_t;

endpackage

// File: rtl/instr_loader.sv
// Instruction-memory loader: streams words over valid/ready into consecutive
// addresses from 0 and holds the CPU while loading.
// Optional trailing checksum word: define INSTR_LOADER_CHECKSUM_EN.
module instr_loader
  import instr_pkg::state_t, instr_pkg::IDLE, instr_pkg::LOAD,
         instr_pkg::CHECK, instr_pkg::DONE;
#(
  parameter int unsigned D = instr_pkg::D,
  parameter int unsigned W = instr_pkg::W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [D:0]   load_len,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         wr_en,
  output logic [D-1:0] wr_addr,
  output logic [W-1:0] wr_data,
  output logic         busy,
  output logic         cpu_hold,
  output logic         done,
  output logic         err
);

  localparam logic [D:0] MAX_LEN = {1'b1, {D{1'b0}}};

`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CHECK;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t     state;
  state_t     state_nxt;
  logic [D:0] cnt;
  logic [D:0] len;
  logic [D:0] len_clamp_c;
  logic       hs_c;
  logic       last_c;

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [W-1:0] acc;
`else
  assign err = 1'b0;
`endif

  // Length clamp, handshake and last-word detection.
  always_comb begin
    len_clamp_c = (load_len > MAX_LEN) ? MAX_LEN : load_len;
    hs_c        = in_valid & in_ready;
    last_c      = ((cnt + (D+1)'(1)) == len);
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len_clamp_c == '0) ? AFTER_DATA : LOAD;
      LOAD:    if (hs_c && last_c) state_nxt = AFTER_DATA;
`ifdef INSTR_LOADER_CHECKSUM_EN
      CHECK:   if (hs_c) state_nxt = DONE;
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, datapath and outputs; status outputs are decoded from
  // the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      len      <= '0;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      acc      <= '0;
      err      <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == LOAD) || (state_nxt == CHECK);
      busy     <= (state_nxt != IDLE);
      cpu_hold <= (state_nxt != IDLE);
      done     <= (state_nxt == DONE);
      wr_en    <= 1'b0;

      if ((state == IDLE) && start) begin
        len <= len_clamp_c;
        cnt <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
        acc <= '0;
        err <= 1'b0;
`endif
      end

      if ((state == LOAD) && hs_c) begin
        wr_en   <= 1'b1;
        wr_addr <= cnt[D-1:0];
        wr_data <= in_data;
        cnt     <= cnt + (D+1)'(1);
`ifdef INSTR_LOADER_CHECKSUM_EN
        acc     <= acc + in_data;
`endif
      end

`ifdef INSTR_LOADER_CHECKSUM_EN
      if ((state == CHECK) && hs_c) err <= (in_data != acc);
`endif
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader against a queue-based load model.
module tb_instr_loader;

  localparam int unsigned D     = 12;
  localparam int unsigned W     = 9;
  localparam int unsigned DEPTH = 1 << D;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [D:0]   load_len;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         wr_en;
  logic [D-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic         busy;
  logic         cpu_hold;
  logic         done;
  logic         err;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned cyc    = 0;
  int unsigned done_n = 0;
  int unsigned done_cyc = 0;
  int unsigned kick_cyc = 0;

  logic [D-1:0]       wa_q[$];
  logic [W-1:0]       wd_q[$];
  int unsigned        wc_q[$];
  logic [W-1:0]       src_q[$];
  instr_pkg::mach_word_t fx_q[$];

  instr_loader dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Write/done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      wc_q.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
  endtask

  task automatic kick(input logic [D:0] len);
    start    = 1'b1;
    load_len = len;
    tick();
    start    = 1'b0;
    kick_cyc = cyc;
  endtask

  // One complete load: model the expected write stream, feed the words and
  // compare writes, done count, idle return and error flag.
  task automatic run_load(input string tag, input logic [D:0] len_req,
                          input int vpct, input bit toggle,
                          input int start_at, input bit bad_sum);
    logic [W-1:0] exp_q[$];
    logic [W-1:0] w;
    logic [W-1:0] sum;
    logic         exp_err;
    int           n;
    int           nbad;
    bit           ok;
    int unsigned  d0;
    n   = (int'(len_req) > int'(DEPTH)) ? int'(DEPTH) : int'(len_req);
    sum = '0;
    for (int i = 0; i < n; i++) begin
      w = (i < fx_q.size()) ? fx_q[i] : W'($urandom);
      exp_q.push_back(w);
      sum = sum + w;
    end
    src_q = exp_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    src_q.push_back(sum ^ W'(bad_sum));
    exp_err = bad_sum;
`else
    exp_err = 1'b0;
`endif
    clear_mon();
    d0 = done_n;
    kick(len_req);
    ok = 1'b0;
    for (int c = 0; c < 8 * n + 40; c++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (c == start_at) begin
        start    = 1'b1;
        load_len = (D+1)'(1);
      end else begin
        start = 1'b0;
      end
      in_valid = (src_q.size() > 0) &&
                 (toggle ? (c % 2 == 0) : (int'($urandom_range(99)) < vpct));
      in_data  = in_valid ? src_q[0] : W'($urandom);
      #3;
      if (in_valid && in_ready) void'(src_q.pop_front());
      tick();
    end
    in_valid = 1'b0;
    start    = 1'b0;
    total++;
    if (!ok) $display("FAIL %s_timeout: done not seen, got 0 want 1", tag);
    else passed++;
    tick();
    total++;
    if ({busy, cpu_hold} !== 2'b00)
      $display("FAIL %s_idle: busy/hold got %b want 00", tag, {busy, cpu_hold});
    else passed++;
    total++;
    if (done_n - d0 !== 1)
      $display("FAIL %s_done_count: got %0d want 1", tag, done_n - d0);
    else passed++;
    total++;
    if (wa_q.size() !== n)
      $display("FAIL %s_write_count: got %0d want %0d", tag, wa_q.size(), n);
    else passed++;
    nbad = 0;
    for (int i = 0; i < n && i < wa_q.size(); i++)
      if (wa_q[i] !== D'(i) || wd_q[i] !== exp_q[i]) nbad++;
    total++;
    if (nbad !== 0) $display("FAIL %s_write_data: got %0d bad writes want 0", tag, nbad);
    else passed++;
    total++;
    if (err !== exp_err) $display("FAIL %s_err: got %b want %b", tag, err, exp_err);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; load_len = '0; in_valid = 1'b0; in_data = '0;
    #1;
    total++;
    if ({wr_en, busy, cpu_hold, done, in_ready, err} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000", {wr_en, busy, cpu_hold, done, in_ready, err});
    else passed++;
    total++;
    if ({wr_addr, wr_data} !== '0)
      $display("FAIL reset_bus: got %h want 0", {wr_addr, wr_data});
    else passed++;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_len4();
    fx_q = '{9'h07E, 9'h066, 9'h07A, 9'h1DE};
    run_load("len4", 13'd4, 100, 1'b0, -1, 1'b0);
    fx_q.delete();
    total++;
    if (wc_q.size() != 4 || wc_q[0] != kick_cyc + 1 || wc_q[3] != kick_cyc + 4)
      $display("FAIL len4_write_timing: got first %0d last %0d want %0d..%0d",
               (wc_q.size() > 0) ? wc_q[0] : 0, (wc_q.size() > 3) ? wc_q[3] : 0,
               kick_cyc + 1, kick_cyc + 4);
    else passed++;
`ifndef INSTR_LOADER_CHECKSUM_EN
    total++;
    if (done_cyc != kick_cyc + 4)
      $display("FAIL len4_done_cycle: got %0d want %0d", done_cyc, kick_cyc + 4);
    else passed++;
`endif
  endtask

  task automatic test_toggle_len3();
    run_load("toggle3", 13'd3, 0, 1'b1, -1, 1'b0);
  endtask

  task automatic test_zero_len();
    int unsigned d0;
    total++;
    if (cpu_hold !== 1'b0) $display("FAIL zero_pre_hold: got %b want 0", cpu_hold);
    else passed++;
`ifdef INSTR_LOADER_CHECKSUM_EN
    run_load("zero", 13'd0, 100, 1'b0, -1, 1'b0);
`else
    clear_mon();
    d0 = done_n;
    kick('0);
    total++;
    if ({done, cpu_hold, busy, in_ready} !== 4'b1110)
      $display("FAIL zero_done_cycle: done/hold/busy/ready got %b want 1110",
               {done, cpu_hold, busy, in_ready});
    else passed++;
    tick();
    total++;
    if ({done, cpu_hold} !== 2'b00)
      $display("FAIL zero_after: done/hold got %b want 00", {done, cpu_hold});
    else passed++;
    total++;
    if (wa_q.size() !== 0 || done_n - d0 !== 1 || done_cyc != kick_cyc)
      $display("FAIL zero_writes_done: got %0d writes %0d dones at %0d want 0,1,%0d",
               wa_q.size(), done_n - d0, done_cyc, kick_cyc);
    else passed++;
`endif
  endtask

  task automatic test_reset_midload();
    int unsigned d0;
    clear_mon();
    d0 = done_n;
    kick(13'd5);
    in_valid = 1'b1;
    in_data  = W'($urandom);
    tick();
    in_data  = W'($urandom);
    tick();
    #2 reset = 1'b1;
    #1;
    total++;
    if ({wr_en, busy, cpu_hold, done, in_ready, err, wr_addr, wr_data} !== '0)
      $display("FAIL midload_reset: got %h want 0",
               {wr_en, busy, cpu_hold, done, in_ready, err, wr_addr, wr_data});
    else passed++;
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    total++;
    if (done_n !== d0) $display("FAIL midload_no_done: got %0d dones want 0", done_n - d0);
    else passed++;
    run_load("after_reset", 13'd1, 100, 1'b0, -1, 1'b0);
  endtask

  task automatic test_ignored_inputs();
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = W'($urandom);
      tick();
      total++;
      if (in_ready !== 1'b0) $display("FAIL idle_ready: got %b want 0", in_ready);
      else passed++;
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (wa_q.size() !== 0) $display("FAIL idle_writes: got %0d want 0", wa_q.size());
    else passed++;
    run_load("start_in_load", 13'd6, 100, 1'b0, 2, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++)
      run_load($sformatf("rand%0d", k), (D+1)'($urandom_range(1, 20)),
               int'($urandom_range(30, 100)), 1'b0, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_load("b2b_a", 13'd5, 70, 1'b0, -1, 1'b0);
    run_load("b2b_b", 13'd2, 100, 1'b0, -1, 1'b0);
  endtask

  task automatic test_clamp();
    run_load("clamp", 13'h1FFF, 100, 1'b0, -1, 1'b0);
  endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    fx_q = '{9'h100, 9'h150};
    run_load("cksum_ok", 13'd2, 100, 1'b0, -1, 1'b0);
    run_load("cksum_bad", 13'd2, 100, 1'b0, -1, 1'b1);
    fx_q.delete();
    tick(); tick(); tick();
    total++;
    if (err !== 1'b1) $display("FAIL cksum_sticky: got %b want 1", err);
    else passed++;
    run_load("cksum_clear", 13'd3, 100, 1'b0, -1, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_len4();
    test_toggle_len3();
    test_zero_len();
    test_reset_midload();
    test_ignored_inputs();
    test_random();
    test_back_to_back();
    test_clamp();
`ifdef INSTR_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
